// File: rtl/ita_output_writer.sv
// ITA output writer: accepts requantized N-lane vectors over valid/ready and writes them to
// memory in tiled order (row within tile, column tile, row tile) through a 2-entry buffer.
module ita_output_writer #(
  parameter int unsigned N         = 16,
  parameter int unsigned WI        = 8,
  parameter int unsigned TileRows  = 64,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] row_stride_i,
  input  logic [CntWidth-1:0]  n_row_tiles_i,
  input  logic [CntWidth-1:0]  n_col_tiles_i,
  input  logic                 inp_valid_i,
  output logic                 inp_ready_o,
  input  logic [N*WI-1:0]      inp_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [N*WI-1:0]      mem_wdata_o,
  output logic                 mem_we_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned DataWidth = N * WI;
  localparam int unsigned BeatBytes = DataWidth / 8;
  localparam int unsigned RowWidth  = (TileRows > 1) ? $clog2(TileRows) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } entry_t;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;

  logic [AddrWidth-1:0] r_stride;
  logic [CntWidth-1:0]  r_nrow;
  logic [CntWidth-1:0]  r_ncol;
  logic [RowWidth-1:0]  r_row;
  logic [CntWidth-1:0]  r_col;
  logic [CntWidth-1:0]  r_tile;
  logic [AddrWidth-1:0] r_tile_ptr;
  logic [AddrWidth-1:0] r_row_ptr;
  logic [AddrWidth-1:0] r_col_off;

  entry_t               r_fifo [2];
  logic                 r_rd_ptr;
  logic                 r_wr_ptr;
  logic [1:0]           r_cnt;

  logic                 w_start;
  logic                 w_zero_job;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_last_row;
  logic                 w_last_col;
  logic                 w_last_tile;
  logic                 w_last_beat;
  logic [AddrWidth-1:0] w_addr;
  entry_t               w_head;

  assign w_start     = (r_state == S_IDLE) && start_i;
  assign w_zero_job  = (n_row_tiles_i == '0) || (n_col_tiles_i == '0);
  assign inp_ready_o = (r_state == S_RUN) && (r_cnt != 2'd2);
  assign w_push      = inp_valid_i && inp_ready_o;
  assign mem_req_o   = (r_cnt != 2'd0);
  assign w_pop       = mem_req_o && mem_gnt_i;
  assign w_head      = r_fifo[r_rd_ptr];
  assign mem_addr_o  = mem_req_o ? w_head.addr : '0;
  assign mem_wdata_o = mem_req_o ? w_head.data : '0;
  assign mem_we_o    = mem_req_o;
  assign busy_o      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_o      = (r_state == S_DONE);

  assign w_last_row  = (r_row == RowWidth'(TileRows - 1));
  assign w_last_col  = (r_col == r_ncol - CntWidth'(1));
  assign w_last_tile = (r_tile == r_nrow - CntWidth'(1));
  assign w_last_beat = w_push && w_last_row && w_last_col && w_last_tile;
  assign w_addr      = r_row_ptr + r_col_off;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; DRAIN exits on the final grant so done follows it by one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = w_zero_job ? S_DONE : S_RUN;
      S_RUN:   if (w_last_beat) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tiled address walk: row pointer steps by stride; a finished tile's next row starts the next tile
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stride   <= '0;
      r_nrow     <= '0;
      r_ncol     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_tile     <= '0;
      r_tile_ptr <= '0;
      r_row_ptr  <= '0;
      r_col_off  <= '0;
    end else if (w_start) begin
      r_stride   <= row_stride_i;
      r_nrow     <= n_row_tiles_i;
      r_ncol     <= n_col_tiles_i;
      r_row      <= '0;
      r_col      <= '0;
      r_tile     <= '0;
      r_tile_ptr <= base_addr_i;
      r_row_ptr  <= base_addr_i;
      r_col_off  <= '0;
    end else if (w_push) begin
      if (!w_last_row) begin
        r_row     <= r_row + RowWidth'(1);
        r_row_ptr <= r_row_ptr + r_stride;
      end else begin
        r_row <= '0;
        if (!w_last_col) begin
          r_col     <= r_col + CntWidth'(1);
          r_col_off <= r_col_off + AddrWidth'(BeatBytes);
          r_row_ptr <= r_tile_ptr;
        end else begin
          r_col      <= '0;
          r_col_off  <= '0;
          r_tile     <= r_tile + CntWidth'(1);
          r_tile_ptr <= r_row_ptr + r_stride;
          r_row_ptr  <= r_row_ptr + r_stride;
        end
      end
    end
  end

  // Two-entry FIFO of {addr, data}
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= '{addr: w_addr, data: inp_i};
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ita_output_writer.sv
// Directed self-checking bench for ita_output_writer (TileRows overridden to 4).
module tb_ita_output_writer;

  localparam int unsigned DW = 128;

  logic          clk;
  logic          rst_i;
  logic          start_i;
  logic [31:0]   base_addr_i;
  logic [31:0]   row_stride_i;
  logic [15:0]   n_row_tiles_i;
  logic [15:0]   n_col_tiles_i;
  logic          inp_valid_i;
  logic          inp_ready_o;
  logic [DW-1:0] inp_i;
  logic          mem_req_o;
  logic          mem_gnt_i;
  logic [31:0]   mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_we_o;
  logic          busy_o;
  logic          done_o;

  ita_output_writer #(.N(16), .WI(8), .TileRows(4), .AddrWidth(32), .CntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .row_stride_i(row_stride_i), .n_row_tiles_i(n_row_tiles_i), .n_col_tiles_i(n_col_tiles_i),
    .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o), .inp_i(inp_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    int unsigned beat;
    logic [31:0] exp_off;
  } wr_t;

  int          n_err = 0;
  int          n_checks = 0;
  int          cyc = 0;
  int          gnt_mode = 0;   // 0: held high, 1: random, 2: held low
  int          last_gnt_cyc = 0;
  int          done_cyc = 0;
  int          n_done = 0;
  logic [31:0] wq_addr [$];
  logic [DW-1:0] wq_data [$];
  wr_t         tbl [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    mem_gnt_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (gnt_mode)
        0:       mem_gnt_i = 1'b1;
        1:       mem_gnt_i = 1'($urandom_range(0, 1));
        default: mem_gnt_i = 1'b0;
      endcase
    end
  end

  // Write monitor, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (mem_req_o && mem_gnt_i) begin
      wq_addr.push_back(mem_addr_o);
      wq_data.push_back(mem_wdata_o);
      last_gnt_cyc = cyc;
    end
    if (done_o) begin
      done_cyc = cyc;
      n_done++;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] base, input logic [31:0] stride,
                           input logic [15:0] nrow, input logic [15:0] ncol);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    base_addr_i = base;
    row_stride_i = stride;
    n_row_tiles_i = nrow;
    n_col_tiles_i = ncol;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic feed(input int n, input int unsigned vpct, input int dbase, output int cycles);
    int i;
    i = 0;
    cycles = 0;
    while (i < n && cycles < 2000) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 99) < vpct) begin
        inp_valid_i = 1'b1;
        inp_i = DW'(dbase + i);
      end else begin
        inp_valid_i = 1'b0;
        inp_i = '0;
      end
      @(negedge clk);
      cycles++;
      if (inp_valid_i && inp_ready_o) i++;
    end
    @(posedge clk);
    #1;
    inp_valid_i = 1'b0;
    if (i < n) chk("feed_timeout", DW'(i), DW'(n));
  endtask

  task automatic wait_done(input string name);
    int b;
    b = 0;
    @(negedge clk);
    while (!done_o && b < 400) begin
      @(negedge clk);
      b++;
    end
    chk({name, "_done_seen"}, DW'(done_o), DW'(1));
    chk({name, "_busy_with_done"}, DW'(busy_o), DW'(0));
    chk({name, "_done_after_grant"}, DW'(cyc), DW'(last_gnt_cyc + 1));
    @(negedge clk);
    chk({name, "_done_one_cycle"}, DW'(done_o), DW'(0));
  endtask

  task automatic check_tbl(input string name, input int from, input logic [31:0] base, input int dbase);
    chk({name, "_n_writes"}, DW'(wq_addr.size() - from), DW'(8));
    for (int i = 0; i < 8; i++) begin
      if (from + i < wq_addr.size()) begin
        chk($sformatf("%s_addr%0d", name, i), DW'(wq_addr[from + i]), DW'(base + tbl[i].exp_off));
        chk($sformatf("%s_data%0d", name, i), wq_data[from + i], DW'(dbase + int'(tbl[i].beat)));
      end
    end
  endtask

  initial begin
    int from, cyc_used, b, nd;
    logic [31:0] a0, exp_a;
    logic [DW-1:0] d0;

    // Expected order for n_row=1, n_col=2, TileRows=4, stride 0x40, 16-byte beats
    tbl[0] = '{0, 32'h00}; tbl[1] = '{1, 32'h40}; tbl[2] = '{2, 32'h80}; tbl[3] = '{3, 32'hC0};
    tbl[4] = '{4, 32'h10}; tbl[5] = '{5, 32'h50}; tbl[6] = '{6, 32'h90}; tbl[7] = '{7, 32'hD0};

    rst_i = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    row_stride_i = '0;
    n_row_tiles_i = '0;
    n_col_tiles_i = '0;
    inp_valid_i = 1'b0;
    inp_i = '0;
    #3;
    chk("rst_req", DW'(mem_req_o), DW'(0));
    chk("rst_ready", DW'(inp_ready_o), DW'(0));
    chk("rst_busy", DW'(busy_o), DW'(0));
    chk("rst_done", DW'(done_o), DW'(0));
    chk("rst_we", DW'(mem_we_o), DW'(0));
    chk("rst_addr", DW'(mem_addr_o), DW'(0));
    chk("rst_wdata", mem_wdata_o, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // 1: basic job, grant held high
    gnt_mode = 0;
    from = wq_addr.size();
    start_job(32'h1000, 32'h40, 16'd1, 16'd2);
    @(negedge clk);
    chk("t1_busy_after_start", DW'(busy_o), DW'(1));
    feed(8, 100, 0, cyc_used);
    chk("t1_throughput", DW'(cyc_used), DW'(8));
    wait_done("t1");
    check_tbl("t1", from, 32'h1000, 0);

    // 2: grant held low for 5 cycles after the first request
    gnt_mode = 2;
    from = wq_addr.size();
    start_job(32'h1000, 32'h40, 16'd1, 16'd2);
    fork
      feed(8, 100, 0, cyc_used);
      begin
        b = 0;
        @(negedge clk);
        while (!mem_req_o && b < 50) begin
          @(negedge clk);
          b++;
        end
        chk("t2_req_seen", DW'(mem_req_o), DW'(1));
        a0 = mem_addr_o;
        d0 = mem_wdata_o;
        chk("t2_first_addr", DW'(a0), DW'(32'h1000));
        for (int k = 1; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("t2_addr_stable%0d", k), DW'(mem_addr_o), DW'(a0));
          chk($sformatf("t2_data_stable%0d", k), mem_wdata_o, d0);
          chk($sformatf("t2_ready_full%0d", k), DW'(inp_ready_o), DW'(0));
        end
        @(posedge clk);
        #1;
        gnt_mode = 0;
      end
    join
    wait_done("t2");
    check_tbl("t2", from, 32'h1000, 0);

    // 3: random valid/grant, 2x3 tiles, base chosen so addresses wrap past 2^32
    gnt_mode = 1;
    from = wq_addr.size();
    start_job(32'hFFFF_FF80, 32'h40, 16'd2, 16'd3);
    feed(24, 50, 32'h100, cyc_used);
    gnt_mode = 0;
    wait_done("t3");
    chk("t3_n_writes", DW'(wq_addr.size() - from), DW'(24));
    b = 0;
    for (int t = 0; t < 2; t++)
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 4; r++) begin
          exp_a = 32'hFFFF_FF80 + 32'(t * 4 + r) * 32'h40 + 32'(c * 16);
          if (from + b < wq_addr.size()) begin
            chk($sformatf("t3_addr%0d", b), DW'(wq_addr[from + b]), DW'(exp_a));
            chk($sformatf("t3_data%0d", b), wq_data[from + b], DW'(32'h100 + b));
          end
          b++;
        end

    // 4: zero-size job with valid held high
    from = wq_addr.size();
    inp_valid_i = 1'b1;
    inp_i = DW'(32'hABCD);
    start_job(32'h4000, 32'h40, 16'd3, 16'd0);
    @(negedge clk);
    chk("t4_done_pulse", DW'(done_o), DW'(1));
    chk("t4_busy", DW'(busy_o), DW'(0));
    chk("t4_ready", DW'(inp_ready_o), DW'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t4_no_req%0d", k), DW'(mem_req_o), DW'(0));
      chk($sformatf("t4_no_ready%0d", k), DW'(inp_ready_o), DW'(0));
      chk($sformatf("t4_no_done%0d", k), DW'(done_o), DW'(0));
    end
    chk("t4_no_writes", DW'(wq_addr.size() - from), DW'(0));

    // 5: valid in IDLE, then a second start mid-job
    @(negedge clk);
    chk("t5_idle_ready", DW'(inp_ready_o), DW'(0));
    inp_valid_i = 1'b0;
    from = wq_addr.size();
    nd = n_done;
    start_job(32'h1000, 32'h40, 16'd1, 16'd2);
    fork
      feed(8, 100, 32'h20, cyc_used);
      begin
        repeat (3) @(posedge clk);
        #1;
        start_i = 1'b1;
        base_addr_i = 32'h5000;
        n_col_tiles_i = 16'd5;
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
    join
    wait_done("t5");
    check_tbl("t5", from, 32'h1000, 32'h20);
    repeat (3) @(negedge clk);
    chk("t5_single_done", DW'(n_done - nd), DW'(1));
    chk("t5_idle_after", DW'(busy_o), DW'(0));

    // 6: reset with two beats buffered, then a fresh job
    gnt_mode = 2;
    start_job(32'h1000, 32'h40, 16'd1, 16'd2);
    feed(2, 100, 32'h77, cyc_used);
    @(negedge clk);
    chk("t6_req_before_rst", DW'(mem_req_o), DW'(1));
    chk("t6_full_before_rst", DW'(inp_ready_o), DW'(0));
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_req", DW'(mem_req_o), DW'(0));
    chk("t6_rst_busy", DW'(busy_o), DW'(0));
    chk("t6_rst_ready", DW'(inp_ready_o), DW'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    gnt_mode = 0;
    from = wq_addr.size();
    start_job(32'h2000, 32'h40, 16'd1, 16'd2);
    feed(8, 100, 32'h300, cyc_used);
    wait_done("t6");
    check_tbl("t6", from, 32'h2000, 32'h300);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
